hk_mash_111: RTL and testbench

//   HK-MASH 1-1-1 digital delta-sigma modulator: three cascaded first-order error-feedback stages.

---
 rtl/hk_mash_pkg.sv | 19 +
 rtl/hk_efm1_stage.sv | 39 +++
 rtl/hk_mash_111.sv | 115 +++++++++++
 tb/tb_hk_mash_111.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hk_mash_pkg.sv
// Shared constants for the HK-MASH 1-1-1 modulator: output width, output range, dither LFSR.
// The LFSR items are only used when HK_MASH_DITHER_EN is defined.
package hk_mash_pkg;

  localparam int Y_W   = 4;
  localparam int Y_MIN = -3;
  localparam int Y_MAX = 4;

  localparam int              LFSR_W     = 15;
  localparam logic [LFSR_W-1:0] LFSR_SEED  = 15'h1;
  localparam int              LFSR_TAP_A = 14;
  localparam int              LFSR_TAP_B = 13;

  // Fibonacci step for x^15 + x^14 + 1
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
  endfunction

endpackage

// File: rtl/hk_efm1_stage.sv
// One first-order error-feedback accumulator stage with optional feedback gain on its own
// delayed carry (HK stage) and a one-LSB dither input.
module hk_efm1_stage #(
  parameter int WIDTH   = 20,
  parameter int FB_GAIN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_i,
  input  logic             fb_i,
  input  logic             dith_i,
  output logic             carry_o,
  output logic [WIDTH-1:0] e_d_o,
  output logic [WIDTH-1:0] e_q_o
);

  logic [WIDTH-1:0] e_q;
  logic [WIDTH+1:0] s_sum;
  logic [WIDTH+1:0] fb_term;

  // Two guard bits keep the HK term and dither from wrapping the sum
  always_comb begin
    fb_term = fb_i ? (WIDTH+2)'(FB_GAIN) : '0;
    s_sum   = {2'b00, in_i} + {2'b00, e_q} + fb_term + {{(WIDTH+1){1'b0}}, dith_i};
  end

  assign carry_o = |s_sum[WIDTH+1:WIDTH];
  assign e_d_o   = s_sum[WIDTH-1:0];
  assign e_q_o   = e_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
    end else begin
      e_q <= e_d_o;
    end
  end

endmodule

// File: rtl/hk_mash_111.sv
// HK-MASH 1-1-1 delta-sigma modulator: three rippled stages, carry delay line, noise-cancelling
// sum and optional output register. Define HK_MASH_DITHER_EN to add a 1-LSB LFSR dither to stage 1.
module hk_mash_111
  import hk_mash_pkg::*;
#(
  parameter int WIDTH   = 20,
  parameter int A_GAIN  = 2,
  parameter int OUT_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      x_i,
  output logic signed [Y_W-1:0] y_o,
  output logic [WIDTH-1:0]      e_o
);

  logic [WIDTH-1:0] st_in   [3];
  logic [WIDTH-1:0] st_e_d  [3];
  logic [WIDTH-1:0] st_e_q  [3];
  logic             st_fb   [3];
  logic             st_dith [3];
  logic             st_carry[3];

  logic c1_q, c2_q, c3_q, c3_qq;
  logic dith;
  logic signed [Y_W-1:0] y_d;

`ifdef HK_MASH_DITHER_EN
  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign dith = lfsr_q[0];
`else
  assign dith = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign st_in[gi]   = x_i;
        assign st_fb[gi]   = c1_q;
        assign st_dith[gi] = dith;
      end else begin : g_chain
        assign st_in[gi]   = st_e_d[gi-1];
        assign st_fb[gi]   = 1'b0;
        assign st_dith[gi] = 1'b0;
      end

      hk_efm1_stage #(
        .WIDTH   (WIDTH),
        .FB_GAIN ((gi == 0) ? A_GAIN : 0)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_i    (st_in[gi]),
        .fb_i    (st_fb[gi]),
        .dith_i  (st_dith[gi]),
        .carry_o (st_carry[gi]),
        .e_d_o   (st_e_d[gi]),
        .e_q_o   (st_e_q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1_q  <= 1'b0;
      c2_q  <= 1'b0;
      c3_q  <= 1'b0;
      c3_qq <= 1'b0;
    end else begin
      c1_q  <= st_carry[0];
      c2_q  <= st_carry[1];
      c3_q  <= st_carry[2];
      c3_qq <= c3_q;
    end
  end

  // y = c1 + (1 - z^-1) c2 + (1 - z^-1)^2 c3, modulo 2^Y_W two's complement
  always_comb begin
    y_d = $signed({3'b000, st_carry[0]})
        + $signed({3'b000, st_carry[1]}) - $signed({3'b000, c2_q})
        + $signed({3'b000, st_carry[2]}) - $signed({2'b00, c3_q, 1'b0})
        + $signed({3'b000, c3_qq});
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic signed [Y_W-1:0] y_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_q <= '0;
        end else begin
          y_q <= y_d;
        end
      end

      assign y_o = y_q;
    end else begin : g_out_comb
      assign y_o = y_d;
    end
  endgenerate

  assign e_o = st_e_q[2];

endmodule

// File: tb/tb_hk_mash_111.sv
// Scoreboard bench for hk_mash_111: combinational and registered-output instances share stimulus,
// an arithmetic reference model feeds an expectation queue that a negedge monitor drains.
module tb_hk_mash_111;

  localparam int    W   = 20;
  localparam int    A   = 2;
  localparam longint MOD = 64'd1 << W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [W-1:0]     x_i = '0;
  logic signed [3:0] y_c, y_r;
  logic [W-1:0]     e_c, e_r;

  hk_mash_111 #(.WIDTH(W), .A_GAIN(A), .OUT_REG(0)) u_comb (
    .clk(clk), .rst_n(rst_n), .x_i(x_i), .y_o(y_c), .e_o(e_c)
  );

  hk_mash_111 #(.WIDTH(W), .A_GAIN(A), .OUT_REG(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .x_i(x_i), .y_o(y_r), .e_o(e_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     yc;
    int     yr;
    longint e;
    bit     show;
    longint x;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   sum_y = 0;
  bit   sum_en = 1'b0;

  // Reference state: residues, carry history and the value the output register holds
  longint m_e1, m_e2, m_e3;
  int     m_c1d, m_c2d, m_c3d, m_c3dd, m_yreg;

  function automatic void model_reset();
    m_e1 = 0; m_e2 = 0; m_e3 = 0;
    m_c1d = 0; m_c2d = 0; m_c3d = 0; m_c3dd = 0; m_yreg = 0;
  endfunction

  function automatic void push_cycle(input longint x, input bit in_rst, input bit show);
    longint s1, s2, s3, n1, n2, n3;
    int c1, c2, c3, y;
    exp_t t;
    s1 = x + m_e1 + A * m_c1d;
    c1 = (s1 >= MOD) ? 1 : 0;
    n1 = (s1 - c1 * MOD) % MOD;
    s2 = n1 + m_e2;
    c2 = (s2 >= MOD) ? 1 : 0;
    n2 = s2 - c2 * MOD;
    s3 = n2 + m_e3;
    c3 = (s3 >= MOD) ? 1 : 0;
    n3 = s3 - c3 * MOD;
    y  = c1 + (c2 - m_c2d) + (c3 - 2 * m_c3d + m_c3dd);
    t.yc = y; t.yr = m_yreg; t.e = m_e3; t.show = show; t.x = x;
    q.push_back(t);
    if (!in_rst) begin
      m_e1 = n1; m_e2 = n2; m_e3 = n3;
      m_c3dd = m_c3d; m_c3d = c3; m_c2d = c2; m_c1d = c1;
      m_yreg = y;
    end
  endfunction

  function automatic void check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: one expectation per falling edge
  initial begin
    exp_t t;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        t = q.pop_front();
        check("y_comb", longint'(y_c), longint'(t.yc));
        check("y_reg",  longint'(y_r), longint'(t.yr));
        check("e_comb", longint'(e_c), t.e);
        check("e_reg",  longint'(e_r), t.e);
        n_cmp++;
        if (int'(y_c) < -3 || int'(y_c) > 4) begin
          n_bad++;
          $display("FAIL y_range: got %0d, expected within -3..4", y_c);
        end
        if (sum_en) sum_y += int'(y_c);
        if (t.show)
          $display("txn x=%05h y_comb=%0d y_reg=%0d e=%05h exp=(%0d,%0d,%05h)",
                   t.x, y_c, y_r, e_c, t.yc, t.yr, t.e);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [W-1:0] x, input bit in_rst, input bit show);
    @(posedge clk);
    #1;
    x_i = x;
    push_cycle(longint'(x), in_rst, show);
  endtask

  task automatic release_rst(input logic [W-1:0] x);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    x_i   = x;
    push_cycle(longint'(x), 1'b0, 1'b1);
  endtask

  // Asynchronous clear mid-cycle, then the model restarts from its reset state
  task automatic assert_rst_midrun();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_y_comb", longint'(y_c), 0);
    check("rst_y_reg",  longint'(y_r), 0);
    check("rst_e_comb", longint'(e_c), 0);
    check("rst_e_reg",  longint'(e_r), 0);
    model_reset();
    push_cycle(longint'(x_i), 1'b1, 1'b1);
  endtask

  initial begin
    int dir_c[3];
    int dir_r[4];
    logic [W-1:0] xr;
    dir_c = '{0, 2, -1};
    dir_r = '{0, 0, 2, -1};
    model_reset();

    // Reset hold with x toggling
    for (int i = 0; i < 20; i++) drive(W'($urandom), 1'b1, 1'b1);

    // Half-scale input: directed start-up sequence, then long-run mean
    sum_y  = 0;
    sum_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) release_rst(W'(1 << 19));
      else        drive(W'(1 << 19), 1'b0, 1'b1);
      @(negedge clk);
      #1;
      if (k < 3) check("start_y_comb", longint'(y_c), longint'(dir_c[k]));
      check("start_y_reg", longint'(y_r), longint'(dir_r[k]));
    end
    for (int i = 4; i < 10000; i++) drive(W'(1 << 19), 1'b0, 1'b0);
    @(negedge clk);
    #1;
    sum_en = 1'b0;
    n_cmp++;
    if (sum_y < 4997 || sum_y > 5003) begin
      n_bad++;
      $display("FAIL half_scale_sum: got %0d, expected 5000 +/- 3", sum_y);
    end

    // Random input with occasional mid-run changes, including extreme codes
    xr = W'($urandom);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0: xr = '0;
          1: xr = '1;
          2: xr = W'(MOD - 2);
          default: xr = W'($urandom);
        endcase
      end
      drive(xr, 1'b0, 1'b1);
    end

    // Zero input from reset stays silent
    assert_rst_midrun();
    for (int i = 0; i < 3; i++) drive('0, 1'b1, 1'b1);
    release_rst('0);
    sum_y  = 0;
    sum_en = 1'b1;
    for (int i = 1; i < 1000; i++) drive('0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    sum_en = 1'b0;
    check("zero_sum", longint'(sum_y), 0);

    // Full-scale input, then asynchronous reset while running
    sum_y  = 0;
    sum_en = 1'b1;
    for (int i = 0; i < 10000; i++) drive('1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    sum_en = 1'b0;
    n_cmp++;
    if (sum_y < 9990 || sum_y > 10010) begin
      n_bad++;
      $display("FAIL full_scale_sum: got %0d, expected about 10000", sum_y);
    end
    assert_rst_midrun();
    for (int i = 0; i < 4; i++) drive(W'($urandom), 1'b1, 1'b1);

    @(negedge clk);
    #1;
    check("queue_drained", longint'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
